// File: rtl/octree_pkg.sv
// Shared types for the octree node ROM request path.
// Response words and child octant encodings used by each fetch port.
package octree_pkg;

  localparam int ROM_DEPTH_DEFAULT = 38;
  localparam int NODE_DATA_W = 32;

  typedef logic [2:0] octant_t;

  typedef struct packed {
    logic                   err;
    logic [NODE_DATA_W-1:0] data;
  } node_rsp_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry response buffer for one octree ROM fetch port.
// Holds captured node words until the traversal unit takes them.
module fetch_fifo2
  import octree_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  node_rsp_t  wdata,
  output node_rsp_t  rdata,
  output logic       empty,
  output logic       full,
  output logic [1:0] occupancy
);

  node_rsp_t  mem_q [2];
  node_rsp_t  mem_d [2];
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;

  // Next-state for storage, pointers and fill count.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata     = mem_q[rd_q];
  assign empty     = (cnt_q == 2'd0);
  assign full      = (cnt_q == 2'd2);
  assign occupancy = cnt_q;

endmodule

// File: rtl/octant_fetch.sv
// Requester-side client for one octree node ROM read port.
// Adds child octant to node base, reads the ROM, returns words in order.
module octant_fetch
  import octree_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ROM_DEPTH     = ROM_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_base,
  input  logic [2:0]               req_octant,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  output logic                     rom_ren,
  input  logic [DATA_WIDTH-1:0]    rom_dout
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT =
    (ADDRESS_WIDTH+1)'(ROM_DEPTH);

  logic [ADDRESS_WIDTH:0] sum;
  logic                   in_range;
  logic                   accept;
  logic                   pop;
  logic                   push;
  logic [2:0]             credit_use;
  logic                   pending_q, pending_d;
  logic                   perr_q, perr_d;
  node_rsp_t              wdata;
  node_rsp_t              head;
  logic                   empty;
  logic                   full;
  logic [1:0]             occ;
  octant_t                oct;

  assign oct = req_octant;

  // Child address with carry kept so wrap-around reads as out of range.
  always_comb begin
    sum      = {1'b0, req_base}
             + {{(ADDRESS_WIDTH-2){1'b0}}, oct};
    in_range = (sum < DEPTH_EXT);
  end

  // Credit accounting, ROM strobe and the capture word for the FIFO.
  always_comb begin
    pop        = rsp_valid && rsp_ready;
    credit_use = {1'b0, occ}
               + {2'b0, pending_q}
               - {2'b0, pop};
    req_ready  = !rst && (credit_use < 3'd2);
    accept     = req_valid && req_ready;
    rom_ren    = accept && in_range;
    rom_addr   = req_valid ? sum[ADDRESS_WIDTH-1:0] : '0;
    pending_d  = accept;
    perr_d     = accept && !in_range;
    wdata.err  = perr_q;
    wdata.data = perr_q ? '0 : rom_dout;
    push       = pending_q && (!full || pop);
  end

  // One-cycle marker for the read whose data appears on rom_dout now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      perr_q    <= perr_d;
    end
  end

  fetch_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     (wdata),
    .rdata     (head),
    .empty     (empty),
    .full      (full),
    .occupancy (occ)
  );

  assign rsp_valid = !empty;
  assign rsp_data  = empty ? '0 : head.data;
  assign rsp_err   = !empty && head.err;

endmodule

// File: tb/tb_octant_fetch.sv
// Bench for octant_fetch: shared ROM model, in-order response model.
// Directed scenarios followed by randomized traffic.
module tb_octant_fetch;
  import octree_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_base = '0;
  logic [2:0]  req_octant = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] rom_addr;
  logic        rom_ren;
  logic [31:0] rom_dout = '0;
  logic        other_ren = 1'b0;
  logic [31:0] other_addr = '0;

  int vectors = 0;
  int miscompares = 0;
  int accepted = 0;
  bit vgate = 1'b1;

  typedef struct {
    logic [31:0] base;
    octant_t     oct;
  } req_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          age;
  } exp_t;

  req_t stim[$];
  exp_t exp_q[$];

  logic [31:0] rom [64];

  always #5 clk = ~clk;

  // Shared ROM port: this port or another client may strobe it.
  always @(posedge clk) begin
    if (rom_ren && rom_addr < 64) rom_dout <= rom[rom_addr[5:0]];
    else if (other_ren) rom_dout <= rom[other_addr[5:0]];
  end

  octant_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_base   (req_base),
    .req_octant (req_octant),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rom_addr   (rom_addr),
    .rom_ren    (rom_ren),
    .rom_dout   (rom_dout)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    if (stim.size() > 0 && vgate) begin
      req_valid  = 1'b1;
      req_base   = stim[0].base;
      req_octant = stim[0].oct;
    end else begin
      req_valid  = 1'b0;
      req_base   = '0;
      req_octant = '0;
    end
  endtask

  // Called at posedge+1; samples mid-cycle, then advances one clock.
  task automatic step();
    bit          ev, ep, er, ea, inr;
    logic [32:0] s;
    drive_inputs();
    #3;
    ev = exp_q.size() > 0 && exp_q[0].age >= 2;
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_data", rsp_data, exp_q[0].data);
      chk("rsp_err", rsp_err, exp_q[0].err);
    end
    ep = ev && rsp_ready;
    er = !rst && (exp_q.size() - int'(ep)) < 2;
    chk("req_ready", req_ready, er);
    s   = {1'b0, req_base} + 33'(req_octant);
    inr = s < 33'd38;
    ea  = req_valid && er;
    chk("rom_ren", rom_ren, ea && inr);
    if (ea && inr) chk("rom_addr", rom_addr, s[31:0]);
    if (!req_valid) chk("rom_addr_idle", rom_addr, 0);
    if (ep) void'(exp_q.pop_front());
    if (ea) begin
      exp_q.push_back('{inr ? 32'h1000 + s[31:0] : 32'h0, !inr, 0});
      accepted++;
      void'(stim.pop_front());
    end
    @(posedge clk);
    #1;
    foreach (exp_q[i]) exp_q[i].age++;
    drive_inputs();
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((stim.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", stim.size() + exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000 + i;

    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rom_ren", rom_ren, 0);
    chk("rst_rom_addr", rom_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Single request, latency two edges
    rsp_ready = 1'b1;
    stim.push_back('{32'd8, 3'd3});
    drain(10);

    // Back-to-back base 0, octants 0..7
    accepted = 0;
    for (int o = 0; o < 8; o++) stim.push_back('{32'd0, 3'(o)});
    for (int k = 0; k < 8; k++) step();
    chk("b2b_accepted", accepted, 8);
    drain(10);

    // Backpressure: four offered, two taken
    rsp_ready = 1'b0;
    accepted = 0;
    for (int o = 0; o < 4; o++) stim.push_back('{32'd0, 3'(o)});
    for (int k = 0; k < 6; k++) step();
    chk("bp_accepted", accepted, 2);
    chk("bp_left", stim.size(), 2);
    chk("bp_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    drain(20);
    chk("bp_total", accepted, 4);

    // Out of range, boundary and carry
    stim.push_back('{32'd35, 3'd3});
    stim.push_back('{32'd34, 3'd3});
    stim.push_back('{32'hFFFF_FFFF, 3'd1});
    drain(12);

    // Another port disturbs rom_dout in N+2
    stim.push_back('{32'd8, 3'd3});
    step();
    other_ren  = 1'b1;
    other_addr = 32'd30;
    step();
    other_ren = 1'b0;
    chk("intf_dout", rom_dout, 32'h101E);
    drain(6);

    // Reset with one buffered and one pending
    rsp_ready = 1'b0;
    stim.push_back('{32'd1, 3'd0});
    stim.push_back('{32'd2, 3'd0});
    step();
    step();
    chk("pre_rst_valid", rsp_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_data", rsp_data, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    stim.push_back('{32'd20, 3'd5});
    drain(10);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if (stim.size() < 2) begin
        if ($urandom_range(0, 7) == 0)
          stim.push_back('{32'hFFFF_FFF8 + $urandom_range(0, 7),
                           3'($urandom_range(0, 7))});
        else
          stim.push_back('{32'($urandom_range(0, 40)),
                           3'($urandom_range(0, 7))});
      end
      vgate     = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    vgate = 1'b1;
    rsp_ready = 1'b1;
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/octant_fetch.md
# octant_fetch

Requester-side client for one read port of the octree node ROM. Takes node fetch requests (node base index plus child octant) from a ray traversal unit over a valid/ready handshake. It drives the ROM port's address and read enable, captures the one-cycle-latency read data, and returns it on a buffered valid/ready response channel. Out-of-range addresses are flagged, not read. One instance sits in front of each of the four ROM ports.

## Interface
- ADDRESS_WIDTH, 32, width of node base and ROM address
- DATA_WIDTH, 32, width of a ROM word / response data
- ROM_DEPTH, 38, number of valid ROM entries; legal addresses 0..ROM_DEPTH-1
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_base  in  ADDRESS_WIDTH  node base index
- req_octant  in  3  child octant 0..7
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready
- rsp_data  out  DATA_WIDTH  node word; 0 when rsp_err
- rsp_err  out  1  address was out of range
- rom_addr  out  ADDRESS_WIDTH  to ROM addr port
- rom_ren  out  1  to ROM ren port
- rom_dout  in  DATA_WIDTH  from ROM dout port

## Operation
- Address: sum = req_base + req_octant, computed in ADDRESS_WIDTH+1 bits (zero-extended). The request is in range iff sum < ROM_DEPTH, including the carry bit.
- Accept (cycle N): rom_addr = sum[ADDRESS_WIDTH-1:0] combinationally. rom_ren = accept && in_range. An out-of-range request never asserts rom_ren.
- Cycle N+1: the pending flag is set. rom_dout (or 0 with err=1 for out-of-range) is written into a 2-entry response FIFO at the end of N+1.
  - rom_dout is captured only in N+1, because the ROM ren is shared across ports and dout may change later.
- Responses are returned in request order. FIFO head drives rsp_data/rsp_err; rsp_valid = FIFO not empty.
- Credit rule: req_ready = (occupancy + pending − pop) < 2, where pop = rsp_valid && rsp_ready. There is a combinational rsp_ready→req_ready path by design. No overflow is possible.
- rom_addr is don't-care when rom_ren is low. It is driven 0 when req_valid is low.
- Reset (async): occupancy, pending and FIFO pointers clear immediately. Any in-flight ROM read is discarded, and its data is ignored after reset.

## Timing
- Reset values: req_ready 0 while rst is high, 1 in the first cycle after release. rsp_valid 0, rsp_data 0, rsp_err 0, rom_ren 0, rom_addr 0.
- Latency: accept in cycle N gives rsp_valid in N+2 (two edges).
- Throughput: 1 request/cycle sustained while rsp_ready is held high.
- Backpressure: with rsp_ready low, at most 2 responses are held (FIFO full, or 1 buffered + 1 pending). req_ready then falls until a pop occurs.
- Simultaneous push and pop with FIFO full is impossible by the credit rule. Simultaneous push and pop with occupancy 1 leaves occupancy 1 and advances the head.
- While rsp_valid && !rsp_ready, rsp_data and rsp_err are stable.

## Structure
- Shared package octree_pkg holds:
  - ROM_DEPTH default constant
  - typedef octant_t (logic [2:0])
  - packed struct node_rsp_t {err, data}
- Sub-module fetch_fifo2: a 2-entry synchronous FIFO of node_rsp_t with push, pop, empty, full and occupancy outputs, using the same async reset.
- The top level holds the address adder, range check, pending flag and credit logic.

## Test plan
- Reset release, ROM preloaded with word[i]=0x1000+i: single request base=8, octant=3 → rom_ren=1, rom_addr=11 in N. rsp_valid in N+2, rsp_data=0x100B, rsp_err=0.
- Back-to-back requests base=0, octant 0..7, rsp_ready held high → 8 responses on consecutive cycles, 0x1000..0x1007 in order, req_ready never drops.
- rsp_ready low, 4 requests offered → exactly 2 accepted, req_ready low afterwards. rsp_data holds 0x1000 stable. Raising rsp_ready drains both, then the remaining 2 are accepted.
- Out of range: base=35, octant=3 (sum 38) → rom_ren stays 0, rsp_err=1, rsp_data=0 at N+2. Base=0xFFFFFFFF, octant=1 (carry) → also err.
- Shared-port interference: another port toggles ren, changing rom_dout in N+2 → the response still carries the N+1 value.
- rst asserted mid-stream with 1 buffered and 1 pending → rsp_valid drops asynchronously. After release, no stale response appears and the next request returns the correct data.
